tea_rr_arbiter: RTL
===================

# tea_rr_arbiter

Round-robin arbiter and sequencer sharing one `tiny_encryption_algorithm` core among `N_REQ` requesters. Per requester it accepts a plaintext/key pair through a valid/ready handshake and drives the core's `ptxt_valid`/`key_valid` level protocol. It returns the ciphertext to the owning requester with a one-cycle response pulse. It sits directly between the requester-side logic and the single TEA core instance, which shares the same `clk`/`rst_n`.

## Interface
- `N_REQ`, default 4: number of requesters, minimum 2.
- `TIMEOUT_CYCLES`, default 255: maximum BUSY cycles before the job is aborted; 0 disables the timeout.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req_valid` in N_REQ: requester i has a job pending; held high until `req_ready[i]` is seen.
- `req_ptxt` in 64*N_REQ: plaintext; requester i occupies `[i*64 +: 64]`.
- `req_key` in 128*N_REQ: key; requester i occupies `[i*128 +: 128]`.
- `req_ready` out N_REQ: one-cycle pulse meaning requester i's job was accepted.
- `rsp_valid` out N_REQ: one-cycle pulse meaning the response for requester i is on `rsp_ctxt`/`rsp_err`.
- `rsp_ctxt` out 64: ciphertext, shared by all requesters.
- `rsp_err` out 1: qualifies `rsp_valid`; 1 means the job timed out and `rsp_ctxt` is 0.
- `core_ptxt_valid` out 1: to core `ptxt_valid`.
- `core_key_valid` out 1: to core `key_valid`; always equal to `core_ptxt_valid`.
- `core_ptxt_blk` out 64: to core `ptxt_blk`.
- `core_key` out 128: to core `key`.
- `core_ctxt_blk` in 64: from core `ctxt_blk`.
- `core_ctxt_ready` in 1: from core `ctxt_ready`.

## Operation
**FSM states:** IDLE, BUSY, DRAIN. The reset state is IDLE.

**IDLE**
- If any `req_valid` bit is high, select the first set bit searching upward from `rr_ptr+1` modulo `N_REQ`.
- At that edge:
  - latch that requester's plaintext and key into `core_ptxt_blk`/`core_key`;
  - set `grant_idx` and `rr_ptr` to the selected index;
  - set `req_ready[grant_idx]`;
  - set the core valids to 1;
  - clear the timeout counter;
  - go to BUSY.
- Otherwise stay in IDLE.

**BUSY**
- Core valids stay high and the latched data is stable.
- On an edge where `core_ctxt_ready` is 1:
  - `rsp_ctxt <= core_ctxt_blk`, `rsp_err <= 0`;
  - set `rsp_valid[grant_idx]`;
  - clear the core valids;
  - go to DRAIN.
- Timeout, checked when `TIMEOUT_CYCLES` is non-zero and `core_ctxt_ready` is 0: when the counter equals `TIMEOUT_CYCLES`:
  - `rsp_ctxt <= 0`, `rsp_err <= 1`;
  - set `rsp_valid[grant_idx]`;
  - clear the core valids;
  - go to DRAIN.
- Otherwise the counter increments. It saturates and never wraps; width is `$clog2(TIMEOUT_CYCLES+1)`.
- Ready and timeout on the same edge: ready wins and the response is valid data.

**DRAIN**
- Core valids are low.
- Go to IDLE on the first edge where `core_ctxt_ready` is 0. This prevents a stale `ctxt_ready` from completing the next job.
- DRAIN lasts at least one cycle.

**Pulse outputs**
- `req_ready` and `rsp_valid` are registered one-cycle pulses; they auto-clear on the next edge.
- `rsp_ctxt`/`rsp_err` hold their value until the next response.

**Round robin**
- `rr_ptr` resets to `N_REQ-1`, so requester 0 wins the first arbitration.
- `req_valid` bits that rise while not in IDLE wait for the next IDLE.
- Only one job is in flight at a time.

## Timing
**Reset values:** all outputs 0 (`req_ready`, `rsp_valid`, `rsp_ctxt`, `rsp_err`, core valids, `core_ptxt_blk`, `core_key`). Also state=IDLE, `rr_ptr`=`N_REQ-1`, counter=0.

**Reset mid-operation:** everything returns to reset values immediately (asynchronous). No response is issued for the aborted job; the core is reset by the same `rst_n`.

**Latency**
- Acceptance: `req_valid` high at IDLE edge k gives `req_ready` and core valids high in cycle k+1.
- Response: `rsp_valid` is high the cycle after the first edge that samples `core_ctxt_ready`=1.
- Minimum gap between consecutive grants: BUSY (≥1) + DRAIN (≥1) + IDLE (1) cycles.

**Requester obligations**
- Hold `req_valid`, plaintext and key stable until the cycle `req_ready` is seen.
- Drop `req_valid` in that cycle, or keep it high to request a new job. A requester that keeps it high is still subject to round robin against the others.

**Core-side guarantees**
- `core_ptxt_blk`/`core_key` never change while the core valids are 1.
- `core_ptxt_valid` == `core_key_valid` every cycle.

## Test plan
- **Single job:** `N_REQ`=4; only requester 2 sends ptxt=0, key=0. Required response: `req_ready`=4'b0100 for one cycle, core valids held until `core_ctxt_ready`, then `rsp_valid`=4'b0100 with `rsp_ctxt`=64'h41ea3a0a94baa940 and `rsp_err`=0.
- **Fairness:** all four `req_valid` held high continuously with distinct vectors from `tv/`. Required response: grant order 0,1,2,3,0,1… and every `rsp_ctxt` matches its expected ciphertext.
- **Stale ready:** the core model holds `ctxt_ready` high for 3 cycles after the valids drop, with a second request already pending. Required response: the arbiter stays in DRAIN until ready is 0, and the second response carries the second job's ciphertext, not the first.
- **Timeout:** `TIMEOUT_CYCLES`=8 and a stub core that never asserts ready. Required response: `rsp_valid` for the granted requester with `rsp_err`=1 and `rsp_ctxt`=0 after 8 BUSY cycles, core valids low, and the next requester granted afterwards.
- **Ready and timeout on the same edge:** ready arrives exactly at the counter = `TIMEOUT_CYCLES` edge. Required response: `rsp_err`=0 and the data is returned.
- **Reset mid-job:** assert `rst_n`=0 during BUSY. Required response: all outputs 0 asynchronously and no `rsp_valid` is issued. After release, requester 0 wins first even if requester 3 was granted before the reset.

Source files
------------

// File: rtl/tea_rr_arbiter.sv
// Round-robin front end that time-shares a single TEA core between N_REQ requesters.
//
// state | meaning
// IDLE  | no job in flight; arbitrate among req_valid
// BUSY  | core valids high, waiting for ctxt_ready or the timeout
// DRAIN | core valids low, waiting for the core to drop ctxt_ready

module tea_rr_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [64*N_REQ-1:0]  req_ptxt,
  input  logic [128*N_REQ-1:0] req_key,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [63:0]          rsp_ctxt,
  output logic                 rsp_err,
  output logic                 core_ptxt_valid,
  output logic                 core_key_valid,
  output logic [63:0]          core_ptxt_blk,
  output logic [127:0]         core_key,
  input  logic [63:0]          core_ctxt_blk,
  input  logic                 core_ctxt_ready
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IW-1:0] PTR_RST    = IW'(N_REQ - 1);
  localparam logic [CW-1:0] CNT_LIMIT  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_SAT    = '1;
  localparam bit            TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   rr_ptr, rr_ptr_nx;
  logic [IW-1:0]   grant_idx, grant_idx_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [N_REQ-1:0] req_ready_nx, rsp_valid_nx;
  logic [63:0]     rsp_ctxt_nx;
  logic            rsp_err_nx;
  logic            core_valid, core_valid_nx;
  logic [63:0]     ptxt_nx;
  logic [127:0]    key_nx;

  logic [63:0]     ptxt_arr [N_REQ];
  logic [127:0]    key_arr  [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign ptxt_arr[g] = req_ptxt[g*64 +: 64];
    assign key_arr[g]  = req_key[g*128 +: 128];
  end

  // Search upward from the requester after the last winner, wrapping at N_REQ.
  logic            found;
  logic [IW-1:0]   sel_idx;
  logic [IW-1:0]   cand;
  int              pos;

  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    cand    = '0;
    pos     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos  = (int'(rr_ptr) + k) % N_REQ;
      cand = IW'(pos);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        sel_idx = cand;
      end
    end
  end

  always_comb begin
    state_nx      = state;
    rr_ptr_nx     = rr_ptr;
    grant_idx_nx  = grant_idx;
    cnt_nx        = cnt;
    req_ready_nx  = '0;
    rsp_valid_nx  = '0;
    rsp_ctxt_nx   = rsp_ctxt;
    rsp_err_nx    = rsp_err;
    core_valid_nx = core_valid;
    ptxt_nx       = core_ptxt_blk;
    key_nx        = core_key;

    case (state)
      S_IDLE: begin
        if (found) begin
          ptxt_nx               = ptxt_arr[sel_idx];
          key_nx                = key_arr[sel_idx];
          grant_idx_nx          = sel_idx;
          rr_ptr_nx             = sel_idx;
          req_ready_nx[sel_idx] = 1'b1;
          core_valid_nx         = 1'b1;
          cnt_nx                = '0;
          state_nx              = S_BUSY;
        end
      end
      S_BUSY: begin
        // A ready on the timeout edge still returns the data.
        if (core_ctxt_ready) begin
          rsp_ctxt_nx             = core_ctxt_blk;
          rsp_err_nx              = 1'b0;
          rsp_valid_nx[grant_idx] = 1'b1;
          core_valid_nx           = 1'b0;
          state_nx                = S_DRAIN;
        end else if (TIMEOUT_EN && (cnt == CNT_LIMIT)) begin
          rsp_ctxt_nx             = '0;
          rsp_err_nx              = 1'b1;
          rsp_valid_nx[grant_idx] = 1'b1;
          core_valid_nx           = 1'b0;
          state_nx                = S_DRAIN;
        end else if (cnt != CNT_SAT) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        // A ready left over from the finished job must not complete the next one.
        if (!core_ctxt_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx      = S_IDLE;
        core_valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      rr_ptr        <= PTR_RST;
      grant_idx     <= '0;
      cnt           <= '0;
      req_ready     <= '0;
      rsp_valid     <= '0;
      rsp_ctxt      <= '0;
      rsp_err       <= 1'b0;
      core_valid    <= 1'b0;
      core_ptxt_blk <= '0;
      core_key      <= '0;
    end else begin
      state         <= state_nx;
      rr_ptr        <= rr_ptr_nx;
      grant_idx     <= grant_idx_nx;
      cnt           <= cnt_nx;
      req_ready     <= req_ready_nx;
      rsp_valid     <= rsp_valid_nx;
      rsp_ctxt      <= rsp_ctxt_nx;
      rsp_err       <= rsp_err_nx;
      core_valid    <= core_valid_nx;
      core_ptxt_blk <= ptxt_nx;
      core_key      <= key_nx;
    end
  end

  assign core_ptxt_valid = core_valid;
  assign core_key_valid  = core_valid;

endmodule
